// File: rtl/dmem_mmio_responder.sv
// dmem_mmio_responder
//   Memory-mapped peripheral block sitting on the processor data-memory bus.
//   It decodes word addresses 0xF00..0xFFF and provides an LED register, a
//   free-running timer with compare/interrupt, and an 8-deep transmit FIFO.
//
// Ports
//   clock     in   1   master clock, rising-edge active
//   reset     in   1   asynchronous active-high reset
//   address   in  12   processor dmem word address
//   data      in  32   processor write data
//   wren      in   1   processor write enable
//   q         out 32   registered read data (one-cycle latency)
//   led       out 16   LED register contents
//   tx_data   out  8   head entry of the transmit FIFO
//   tx_valid  out  1   transmit FIFO non-empty
//   tx_ready  in   1   consumer accepts tx_data this cycle
//   irq       out  1   timer interrupt request (match & irq_en)
//
// Register map (address[7:0] within the 0xF page)
//   0x00 LED    RW  bits[15:0]
//   0x01 TIMER  RW
//   0x02 CMP    RW
//   0x03 CTRL   RW  bit0 timer_en, bit1 irq_en
//   0x04 STATUS     bit0 match (W1C), bit1 full, bit2 empty,
//                   bit3 overflow (W1C), bits[7:4] FIFO count
//   0x05 TXDATA WO  write pushes data[7:0]; reads 0
//
// Transmit handshake: an entry leaves the FIFO on any rising edge where
// tx_valid and tx_ready are both high; tx_valid never depends on tx_ready,
// and tx_data holds steady while tx_valid is high and tx_ready is low.
module dmem_mmio_responder (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] address,
  input  logic [31:0] data,
  input  logic        wren,
  output logic [31:0] q,
  output logic [15:0] led,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        irq
);

  localparam logic [7:0] REG_LED    = 8'h00;
  localparam logic [7:0] REG_TIMER  = 8'h01;
  localparam logic [7:0] REG_CMP    = 8'h02;
  localparam logic [7:0] REG_CTRL   = 8'h03;
  localparam logic [7:0] REG_STATUS = 8'h04;
  localparam logic [7:0] REG_TXDATA = 8'h05;

  logic [15:0] led_r;
  logic [31:0] timer_r;
  logic [31:0] cmp_r;
  logic [1:0]  ctrl_r;
  logic        match_r;
  logic        overflow_r;

  logic [7:0]  fifo_mem [8];
  logic [2:0]  wr_ptr;
  logic [2:0]  rd_ptr;
  logic [3:0]  count;

  logic        sel;
  logic [7:0]  offset;
  logic        wr_sel;
  logic        timer_en;
  logic        irq_en;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic        accept;
  logic        match_set;
  logic [31:0] status_word;
  logic [31:0] read_mux;

  assign sel      = (address[11:8] == 4'hF);
  assign offset   = address[7:0];
  assign wr_sel   = wren & sel;
  assign timer_en = ctrl_r[0];
  assign irq_en   = ctrl_r[1];

  assign full     = (count == 4'd8);
  assign empty    = (count == 4'd0);
  assign tx_valid = ~empty;
  assign tx_data  = fifo_mem[rd_ptr];
  assign pop      = tx_valid & tx_ready;
  assign push     = wr_sel & (offset == REG_TXDATA);
  // When full, a same-cycle pop frees the head slot, which is exactly the
  // slot wr_ptr points at, so the push can land there.
  assign accept   = push & (~full | pop);

  assign match_set = timer_en & (timer_r == cmp_r);

  assign led = led_r;
  assign irq = match_r & irq_en;

  assign status_word = {24'd0, count, overflow_r, empty, full, match_r};

  // Read mux sees pre-write values, so a same-cycle read+write returns the
  // old contents.
  always_comb begin
    read_mux = 32'd0;
    if (sel) begin
      case (offset)
        REG_LED:    read_mux = {16'd0, led_r};
        REG_TIMER:  read_mux = timer_r;
        REG_CMP:    read_mux = cmp_r;
        REG_CTRL:   read_mux = {30'd0, ctrl_r};
        REG_STATUS: read_mux = status_word;
        default:    read_mux = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q          <= 32'd0;
      led_r      <= 16'd0;
      timer_r    <= 32'd0;
      cmp_r      <= 32'd0;
      ctrl_r     <= 2'd0;
      match_r    <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      q <= read_mux;

      if (wr_sel && offset == REG_LED) led_r <= data[15:0];
      if (wr_sel && offset == REG_CMP) cmp_r <= data;
      if (wr_sel && offset == REG_CTRL) ctrl_r <= data[1:0];

      // Software write beats the increment.
      if (wr_sel && offset == REG_TIMER) timer_r <= data;
      else if (timer_en)                 timer_r <= timer_r + 32'd1;

      // W1C flags: a hardware set in the same cycle wins over the clear.
      if (match_set)
        match_r <= 1'b1;
      else if (wr_sel && offset == REG_STATUS && data[0])
        match_r <= 1'b0;

      if (push && !accept)
        overflow_r <= 1'b1;
      else if (wr_sel && offset == REG_STATUS && data[3])
        overflow_r <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= 3'd0;
      rd_ptr <= 3'd0;
      count  <= 4'd0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 3'd1;
      if (pop)    rd_ptr <= rd_ptr + 3'd1;
      if (accept && !pop)      count <= count + 4'd1;
      else if (pop && !accept) count <= count - 4'd1;
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clock) begin
    if (accept) fifo_mem[wr_ptr] <= data[7:0];
  end

endmodule
